// File: rtl/pcie_phy_pkg.sv
// pcie_phy_pkg: shared types and helpers for the PCIe PHY wrapper.
// Rev 1.0 - GT reset sequencer state encoding and output decode.
`default_nettype none

package pcie_phy_pkg;

  localparam int GT_RST_STATE_W = 3;

  typedef enum logic [GT_RST_STATE_W-1:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    GT_RST    = 3'd2,
    WAIT_DONE = 3'd3,
    USRRDY    = 3'd4,
    READY     = 3'd5,
    FAIL      = 3'd6
  } gt_rst_state_t;

  typedef struct packed {
    logic pll_reset;
    logic tx_reset;
    logic rx_reset;
    logic userrdy;
    logic phy_ready;
    logic fatal_err;
  } gt_rst_outs_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic gt_rst_outs_t decode_outputs(input gt_rst_state_t st);
    gt_rst_outs_t o;
    o           = '0;
    o.pll_reset = (st == PLL_RST);
    o.tx_reset  = (st == PLL_RST) || (st == WAIT_LOCK) || (st == GT_RST);
    o.rx_reset  = o.tx_reset;
    o.userrdy   = (st == USRRDY) || (st == READY);
    o.phy_ready = (st == READY);
    o.fatal_err = (st == FAIL);
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
// bit_sync: multi-stage flop synchronizer for quasi-static status bits.
// Rev 1.0 - initial release.
`default_nettype none

module bit_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pcie_gt_rst_seq.sv
// pcie_gt_rst_seq: GT reset sequencer (PLL reset, lock, datapath reset, USERRDY).
// Rev 1.0 - bounded retry on timeout/loss, absorbing FAIL state.
`default_nettype none

module pcie_gt_rst_seq
  import pcie_phy_pkg::*;
#(
  parameter int PLL_RST_CYC = 32,
  parameter int GT_RST_CYC  = 16,
  parameter int USRRDY_DLY  = 8,
  parameter int LOCK_TMO    = 65536,
  parameter int DONE_TMO    = 65536,
  parameter int MAX_RETRY   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      restart,
  input  logic                      pll_lock_async,
  input  logic                      tx_resetdone_async,
  input  logic                      rx_resetdone_async,
  output logic                      pll_reset,
  output logic                      tx_reset,
  output logic                      rx_reset,
  output logic                      userrdy,
  output logic                      phy_ready,
  output logic                      fatal_err,
  output logic [1:0]                retry_cnt,
  output logic [GT_RST_STATE_W-1:0] state_dbg
);

  localparam int CNT_MAX = max_int(max_int(max_int(PLL_RST_CYC, GT_RST_CYC),
                                           max_int(USRRDY_DLY, LOCK_TMO)), DONE_TMO);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] c_pll_load  = CNT_W'(PLL_RST_CYC);
  localparam logic [CNT_W-1:0] c_gt_load   = CNT_W'(GT_RST_CYC);
  localparam logic [CNT_W-1:0] c_urdy_load = CNT_W'(USRRDY_DLY);
  localparam logic [CNT_W-1:0] c_lock_load = CNT_W'(LOCK_TMO);
  localparam logic [CNT_W-1:0] c_done_load = CNT_W'(DONE_TMO);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
  localparam logic [1:0]       c_max_retry = 2'(MAX_RETRY);

  if (PLL_RST_CYC < 1 || GT_RST_CYC < 1 || USRRDY_DLY < 1 || LOCK_TMO < 1 ||
      DONE_TMO < 1 || MAX_RETRY < 0 || MAX_RETRY > 3 || SYNC_STAGES < 2) begin : g_param_check
    $error("pcie_gt_rst_seq: parameter out of range");
  end

  logic [2:0] sync_vec;
  logic       lock;
  logic       txd;
  logic       rxd;

  bit_sync #(
    .WIDTH  (3),
    .STAGES (SYNC_STAGES)
  ) u_status_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({rx_resetdone_async, tx_resetdone_async, pll_lock_async}),
    .q_o (sync_vec)
  );

  assign lock = sync_vec[0];
  assign txd  = sync_vec[1];
  assign rxd  = sync_vec[2];

  gt_rst_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  gt_rst_outs_t     outs_q, outs_d;
  logic             last_cyc;
  logic             fault;
  logic             enter;

  assign last_cyc = (cnt_q == c_one);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = (cnt_q != '0) ? (cnt_q - c_one) : cnt_q;
    fault   = 1'b0;
    enter   = 1'b0;

    case (state_q)
      PLL_RST: begin
        // A zero count here only happens right after rst: treat as the entry cycle.
        if (last_cyc || (cnt_q == '0 && PLL_RST_CYC == 1)) begin
          state_d = WAIT_LOCK;
          enter   = 1'b1;
        end else if (cnt_q == '0) begin
          cnt_d = c_pll_load - c_one;
        end
      end
      WAIT_LOCK: begin
        if (lock) begin
          state_d = GT_RST;
          enter   = 1'b1;
        end else if (last_cyc) begin
          fault = 1'b1;
        end
      end
      GT_RST: begin
        if (!lock) begin
          fault = 1'b1;
        end else if (last_cyc) begin
          state_d = WAIT_DONE;
          enter   = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!lock) begin
          fault = 1'b1;
        end else if (txd && rxd) begin
          state_d = USRRDY;
          enter   = 1'b1;
        end else if (last_cyc) begin
          fault = 1'b1;
        end
      end
      USRRDY: begin
        if (!(lock && txd && rxd)) begin
          fault = 1'b1;
        end else if (last_cyc) begin
          state_d = READY;
          enter   = 1'b1;
        end
      end
      READY: begin
        if (!lock) begin
          fault = 1'b1;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = PLL_RST;
        enter   = 1'b1;
      end
    endcase

    if (fault) begin
      enter = 1'b1;
      if (retry_q < c_max_retry) begin
        retry_d = retry_q + 2'd1;
        state_d = PLL_RST;
      end else begin
        state_d = FAIL;
      end
    end

    // restart outranks loss/timeout, so any retry increment above is discarded.
    if (restart && state_q != FAIL) begin
      enter   = 1'b1;
      state_d = PLL_RST;
      retry_d = (state_q == READY) ? 2'd0 : retry_q;
    end

    if (enter) begin
      case (state_d)
        PLL_RST:   cnt_d = c_pll_load;
        WAIT_LOCK: cnt_d = c_lock_load;
        GT_RST:    cnt_d = c_gt_load;
        WAIT_DONE: cnt_d = c_done_load;
        USRRDY:    cnt_d = c_urdy_load;
        default:   cnt_d = '0;
      endcase
    end

    outs_d = decode_outputs(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
      retry_q <= 2'd0;
      outs_q  <= decode_outputs(PLL_RST);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      outs_q  <= outs_d;
    end
  end

  assign pll_reset = outs_q.pll_reset;
  assign tx_reset  = outs_q.tx_reset;
  assign rx_reset  = outs_q.rx_reset;
  assign userrdy   = outs_q.userrdy;
  assign phy_ready = outs_q.phy_ready;
  assign fatal_err = outs_q.fatal_err;
  assign retry_cnt = retry_q;
  assign state_dbg = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pcie_gt_rst_seq.sv
// tb_pcie_gt_rst_seq: directed scoreboard bench for the GT reset sequencer.
// Rev 1.0 - expectations keyed to absolute clock-edge numbers.
`default_nettype none

module tb_pcie_gt_rst_seq;

  localparam int S_PLL  = 0;
  localparam int S_WL   = 1;
  localparam int S_GT   = 2;
  localparam int S_WD   = 3;
  localparam int S_URDY = 4;
  localparam int S_RDY  = 5;
  localparam int S_FAIL = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  logic       lock_a = 1'b0;
  logic       txd_a = 1'b0;
  logic       rxd_a = 1'b0;
  logic       pll_reset, tx_reset, rx_reset, userrdy, phy_ready, fatal_err;
  logic [1:0] retry_cnt;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  pcie_gt_rst_seq #(
    .PLL_RST_CYC (4),
    .GT_RST_CYC  (3),
    .USRRDY_DLY  (2),
    .LOCK_TMO    (20),
    .DONE_TMO    (20),
    .MAX_RETRY   (3),
    .SYNC_STAGES (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .restart            (restart),
    .pll_lock_async     (lock_a),
    .tx_resetdone_async (txd_a),
    .rx_resetdone_async (rxd_a),
    .pll_reset          (pll_reset),
    .tx_reset           (tx_reset),
    .rx_reset           (rx_reset),
    .userrdy            (userrdy),
    .phy_ready          (phy_ready),
    .fatal_err          (fatal_err),
    .retry_cnt          (retry_cnt),
    .state_dbg          (state_dbg)
  );

  int edge_no = -1;
  always @(posedge clk) edge_no <= edge_no + 1;

  typedef struct {
    int          tgt;
    string       tag;
    logic [10:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [10:0] mon_act;

  // Expected output vector {pll,tx,rx,userrdy,phy_ready,fatal,retry,state} for a state.
  function automatic logic [10:0] model(input int st, input int rc);
    logic [2:0] s;
    logic [1:0] r;
    s = 3'(st);
    r = 2'(rc);
    return {st == S_PLL, st <= S_GT, st <= S_GT, (st == S_URDY) || (st == S_RDY),
            st == S_RDY, st == S_FAIL, r, s};
  endfunction

  task automatic expect_at(input int tgt, input string tag, input int st, input int rc);
    exp_t e;
    e.tgt = tgt;
    e.tag = tag;
    e.exp = model(st, rc);
    sb.push_back(e);
  endtask

  task automatic after_edge(input int k);
    while (edge_no < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    mon_act = {pll_reset, tx_reset, rx_reset, userrdy, phy_ready, fatal_err, retry_cnt, state_dbg};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].tgt == edge_no) begin
        checks++;
        if (mon_act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s @edge %0d: got %b expected %b (pll,tx,rx,urdy,prdy,fat,retry,state)",
                   sb[i].tag, edge_no, mon_act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, edge %0d", edge_no);
    $fatal(1, "watchdog");
  end

  initial begin
    // Nominal bring-up; rst first sampled low at edge 3 (relative cycle 0).
    expect_at(2,  "reset_state",   S_PLL,  0);
    expect_at(5,  "pll_hold",      S_PLL,  0);
    expect_at(6,  "pll_fall",      S_WL,   0);
    expect_at(14, "wait_lock",     S_WL,   0);
    expect_at(15, "gt_rst_enter",  S_GT,   0);
    expect_at(17, "gt_rst_hold",   S_GT,   0);
    expect_at(18, "gt_rst_fall",   S_WD,   0);
    expect_at(34, "wait_done",     S_WD,   0);
    expect_at(35, "userrdy_rise",  S_URDY, 0);
    expect_at(36, "userrdy_hold",  S_URDY, 0);
    expect_at(37, "phy_ready",     S_RDY,  0);
    after_edge(2);
    rst = 1'b0;
    after_edge(12);
    checks++;
    if (state_dbg !== 3'(S_WL) || pll_reset !== 1'b0) begin
      errors++;
      $display("FAIL direct_wl @edge %0d: state %0d pll_reset %b", edge_no, state_dbg, pll_reset);
    end
    lock_a = 1'b1;
    after_edge(32);
    checks++;
    if (state_dbg !== 3'(S_WD) || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL direct_wd @edge %0d: state %0d retry %0d", edge_no, state_dbg, retry_cnt);
    end
    txd_a = 1'b1;
    rxd_a = 1'b1;

    // One-cycle lock glitch in READY.
    after_edge(44);
    checks++;
    if (state_dbg !== 3'(S_RDY) || phy_ready !== 1'b1) begin
      errors++;
      $display("FAIL direct_ready @edge %0d: state %0d phy_ready %b", edge_no, state_dbg, phy_ready);
    end
    expect_at(46, "glitch_ready",  S_RDY,  0);
    expect_at(47, "loss_to_pll",   S_PLL,  1);
    expect_at(50, "loss_pll_hold", S_PLL,  1);
    expect_at(51, "loss_wl",       S_WL,   1);
    expect_at(52, "loss_gt",       S_GT,   1);
    expect_at(55, "loss_wd",       S_WD,   1);
    expect_at(56, "loss_urdy",     S_URDY, 1);
    expect_at(58, "relock_ready",  S_RDY,  1);
    lock_a = 1'b0;
    after_edge(45);
    lock_a = 1'b1;

    // restart in READY clears the retry count.
    after_edge(61);
    checks++;
    if (state_dbg !== 3'(S_RDY) || retry_cnt !== 2'd1) begin
      errors++;
      $display("FAIL direct_relock @edge %0d: state %0d retry %0d", edge_no, state_dbg, retry_cnt);
    end
    expect_at(61, "pre_restart",   S_RDY,  1);
    expect_at(62, "restart_clr",   S_PLL,  0);
    expect_at(66, "rs_wl",         S_WL,   0);
    expect_at(67, "rs_gt",         S_GT,   0);
    expect_at(70, "rs_wd",         S_WD,   0);
    expect_at(71, "rs_urdy",       S_URDY, 0);
    expect_at(73, "rs_ready",      S_RDY,  0);
    restart = 1'b1;
    after_edge(62);
    restart = 1'b0;

    // restart coinciding with a WAIT_DONE timeout.
    after_edge(75);
    expect_at(80,  "sim_restart",  S_PLL,  0);
    expect_at(84,  "sim_wl",       S_WL,   0);
    expect_at(85,  "sim_gt",       S_GT,   0);
    expect_at(88,  "sim_wd",       S_WD,   0);
    expect_at(107, "sim_pre_tmo",  S_WD,   0);
    expect_at(108, "sim_tmo_rst",  S_PLL,  0);
    txd_a = 1'b0;
    rxd_a = 1'b0;
    after_edge(79);
    restart = 1'b1;
    after_edge(80);
    restart = 1'b0;
    after_edge(107);
    restart = 1'b1;
    after_edge(108);
    restart = 1'b0;

    // rst pulse while in USRRDY.
    after_edge(116);
    expect_at(119, "mid_urdy",     S_URDY, 0);
    expect_at(120, "mid_rst",      S_PLL,  0);
    expect_at(123, "mid_pll_hold", S_PLL,  0);
    expect_at(124, "mid_wl",       S_WL,   0);
    expect_at(131, "mid_ready",    S_RDY,  0);
    txd_a = 1'b1;
    rxd_a = 1'b1;
    after_edge(119);
    rst = 1'b1;
    after_edge(120);
    rst = 1'b0;

    // Lock never arrives: four attempts then FAIL.
    after_edge(139);
    expect_at(140, "tmo_reset",    S_PLL,  0);
    expect_at(144, "tmo_wl0",      S_WL,   0);
    expect_at(163, "tmo_wl0_end",  S_WL,   0);
    expect_at(164, "tmo_retry1",   S_PLL,  1);
    expect_at(188, "tmo_retry2",   S_PLL,  2);
    expect_at(212, "tmo_retry3",   S_PLL,  3);
    expect_at(235, "tmo_wl3_end",  S_WL,   3);
    expect_at(236, "tmo_fail",     S_FAIL, 3);
    expect_at(240, "fail_restart", S_FAIL, 3);
    expect_at(244, "fail_rst",     S_PLL,  0);
    expect_at(246, "fail_cleared", S_PLL,  0);
    rst = 1'b1;
    lock_a = 1'b0;
    after_edge(140);
    rst = 1'b0;
    after_edge(239);
    checks++;
    if (state_dbg !== 3'(S_FAIL) || fatal_err !== 1'b1 || retry_cnt !== 2'd3) begin
      errors++;
      $display("FAIL direct_fail @edge %0d: state %0d fatal %b retry %0d",
               edge_no, state_dbg, fatal_err, retry_cnt);
    end
    restart = 1'b1;
    after_edge(240);
    restart = 1'b0;
    after_edge(243);
    rst = 1'b1;
    after_edge(244);
    rst = 1'b0;

    after_edge(250);
    @(negedge clk);
    #1;
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: never sampled, target edge %0d", sb[i].tag, sb[i].tgt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pcie_gt_rst_seq.md
Name: pcie_gt_rst_seq

Overview:
- Reset sequencer for the Xilinx GT inside the PCIe PHY wrapper.
- Sits directly downstream of the PHY reset synchronizer. Its rst input is the inverted synchronized reset.
- Steps the GT through PLL reset, lock wait, TX/RX datapath reset, resetdone wait and USERRDY, then asserts phy_ready for the LTSSM/PIPE logic.
- Detects loss of lock and timeouts, retries a bounded number of times, then flags a fatal error.

Parameters:
- PLL_RST_CYC, 32: cycles pll_reset is held high; minimum 1.
- GT_RST_CYC, 16: cycles tx_reset/rx_reset are held high; minimum 1.
- USRRDY_DLY, 8: cycles from userrdy rising to phy_ready rising; minimum 1.
- LOCK_TMO, 65536: maximum cycles to wait for PLL lock.
- DONE_TMO, 65536: maximum cycles to wait for both resetdone signals.
- MAX_RETRY, 3: number of retries after the first attempt before FAIL.
- SYNC_STAGES, 2: synchronizer depth for GT status inputs; minimum 2.

Ports:
- clk, in, 1: PHY user clock; free-running before GT lock.
- rst, in, 1: synchronous, active-high reset (one clock; reset is synchronous and active-high).
- restart, in, 1: single-cycle pulse; requests a full resequence.
- pll_lock_async, in, 1: GT PLL lock, asynchronous to clk.
- tx_resetdone_async, in, 1: GT TX reset done, asynchronous to clk.
- rx_resetdone_async, in, 1: GT RX reset done, asynchronous to clk.
- pll_reset, out, 1: GT PLL reset.
- tx_reset, out, 1: GTTXRESET.
- rx_reset, out, 1: GTRXRESET.
- userrdy, out, 1: TX/RX USERRDY.
- phy_ready, out, 1: PHY usable.
- fatal_err, out, 1: retries exhausted.
- retry_cnt, out, 2: retries consumed; saturates at MAX_RETRY.
- state_dbg, out, 3: current state encoding.

Behaviour:
- Input synchronization: the three *_async inputs pass through SYNC_STAGES flops each, reset to 0. All references below are to the synchronized values (lock, txd, rxd).
- Reset values:
  - state = PLL_RST, counter = 0, retry_cnt = 0.
  - pll_reset = tx_reset = rx_reset = 1.
  - userrdy = 0, phy_ready = 0, fatal_err = 0.
- Outputs are registered and Moore-decoded from the state:
  - pll_reset = 1 only in PLL_RST.
  - tx_reset = rx_reset = 1 in PLL_RST, WAIT_LOCK and GT_RST.
  - userrdy = 1 in USRRDY and READY.
  - phy_ready = 1 only in READY.
  - fatal_err = 1 only in FAIL.
- Counter: one shared down-counter. Its width is $clog2 of the largest parameter, plus 1. It is loaded on every state entry.
- State PLL_RST (encoding 0): hold PLL_RST_CYC cycles, then go to WAIT_LOCK.
- State WAIT_LOCK (encoding 1):
  - lock = 1 goes to GT_RST.
  - LOCK_TMO cycles without lock is a timeout.
- State GT_RST (encoding 2):
  - Hold GT_RST_CYC cycles, then go to WAIT_DONE.
  - lock = 0 is a loss event.
- State WAIT_DONE (encoding 3):
  - txd & rxd goes to USRRDY.
  - DONE_TMO cycles without both is a timeout.
  - lock = 0 is a loss event.
- State USRRDY (encoding 4):
  - USRRDY_DLY cycles, then go to READY, provided txd & rxd are still 1.
  - Loss of lock, txd or rxd is a loss event.
- State READY (encoding 5):
  - Stays in READY indefinitely.
  - lock = 0 is a loss event; phy_ready drops the next cycle.
- State FAIL (encoding 6): absorbing. Exits only on rst; restart is ignored.
- Timeout or loss event:
  - If retry_cnt < MAX_RETRY: increment retry_cnt and go to PLL_RST.
  - Otherwise go to FAIL.
- restart pulse in any state except FAIL:
  - Go to PLL_RST.
  - retry_cnt is not incremented.
  - retry_cnt clears to 0 if the current state is READY.
- Priority when events coincide: rst > restart > loss > timeout > normal advance.
- Reset mid-sequence: all state restarts from PLL_RST. No partial state survives.
- Glitch rule: a single-cycle deassertion of a synchronized input is a loss event. There is no debounce.

Decomposition:
- Package pcie_phy_pkg holds:
  - typedef enum logic [2:0] gt_rst_state_t (PLL_RST … FAIL, encodings 0–6);
  - localparam GT_RST_STATE_W = 3.
- Sub-module bit_sync: N-stage flop synchronizer with a width parameter and a reset value of 0. It carries ASYNC_REG and no-SRL attributes and is instantiated once, 3 bits wide.

Test Plan:
- Nominal bring-up (PLL_RST_CYC=4, GT_RST_CYC=3, USRRDY_DLY=2, SYNC_STAGES=2):
  - Stimulus: rst low at cycle 0; lock_async high at cycle 10; both resetdone_async high at cycle 30.
  - Required: pll_reset falls at cycle 4; tx_reset/rx_reset fall 2 + 1 + 3 cycles after lock_async; userrdy rises 3 cycles after resetdone_async; phy_ready rises 2 cycles later; retry_cnt = 0.
- Lock timeout (LOCK_TMO=20, MAX_RETRY=3, lock held 0):
  - Required: exactly 4 PLL_RST entries; retry_cnt reaches 3; fatal_err = 1 after the 4th timeout; pll_reset = 1 held in FAIL is not required, and all resets stay as the FAIL decode gives.
- Loss of lock in READY:
  - Stimulus: drop lock_async for 1 cycle.
  - Required: phy_ready = 0 within SYNC_STAGES + 1 cycles; state_dbg = 0; retry_cnt = 1; re-lock returns to READY.
- restart in READY after one prior retry:
  - Required: retry_cnt clears to 0; pll_reset = 1 the next cycle.
- Simultaneous events: restart in the same cycle as a WAIT_DONE timeout.
  - Required: go to PLL_RST; retry_cnt unchanged.
- Reset mid-operation: assert rst for 1 cycle in USRRDY.
  - Required: all outputs return to reset values the next cycle; sequence restarts; FAIL is cleared by rst.
